// File: rtl/conv_28_24_ctrl_if.sv
// Signal bundle between the 28x28 window scheduler and its environment:
// layer sequencer handshake, image RAM read port, filter datapath and result RAM write port.
interface conv_28_24_ctrl_if #(
    parameter int AW    = 10,
    parameter int PIX_W = 9,
    parameter int SUM_W = 15,
    parameter int K     = 5
);
    logic                   start;
    logic                   busy;
    logic                   done;
    logic                   img_rd;
    logic [AW-1:0]          img_addr;
    logic [PIX_W-1:0]       img_data;
    logic [K*K*PIX_W-1:0]   win;
    logic                   flt_start;
    logic [SUM_W-1:0]       flt_out;
    logic                   flt_end;
    logic                   res_we;
    logic [AW-1:0]          res_addr;
    logic [SUM_W-1:0]       res_data;

    // master: the scheduler, which owns the RAM strobes and the filter trigger
    modport master (
        input  start, img_data, flt_out, flt_end,
        output busy, done, img_rd, img_addr, win, flt_start, res_we, res_addr, res_data
    );

    modport slave (
        output start, img_data, flt_out, flt_end,
        input  busy, done, img_rd, img_addr, win, flt_start, res_we, res_addr, res_data
    );
endinterface

// File: rtl/conv_28_24_ctrl.sv
// Sweeps a 5x5 window over a 28x28 image, fires the filter per window and writes 24x24 sums.
// state | meaning
// IDLE  | waiting for start
// FETCH | one image read per cycle (25 on refill, 5 on step)
// DRAIN | last read data lands in the window
// FIRE  | one-cycle flt_start
// WAIT  | hold window until flt_end, latch flt_out
// WRITE | res_we pulse, advance ox/oy
// DONE  | done pulse, back to IDLE
module conv_28_24_ctrl #(
    parameter int IMG_W = 28,
    parameter int K     = 5,
    parameter int PIX_W = 9,
    parameter int SUM_W = 15,
    parameter int AW    = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    conv_28_24_ctrl_if.master    bus
);

    localparam int OUT_W = IMG_W - K + 1;
    localparam int WIN_W = K * K * PIX_W;
    localparam int CW    = $clog2(OUT_W);
    localparam int RW    = $clog2(K);
    localparam int FW    = $clog2(K * K + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DRAIN, S_FIRE, S_WAIT, S_WRITE, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      oy_q, oy_d;
    logic [CW-1:0]      ox_q, ox_d;
    logic [RW-1:0]      fetch_row_q, fetch_row_d;
    logic [FW-1:0]      fetch_cnt_q, fetch_cnt_d;
    logic [AW-1:0]      img_addr_q, img_addr_d;
    logic               rd_vld_q, rd_vld_d;
    logic [RW-1:0]      rd_row_q, rd_row_d;
    logic [PIX_W-1:0]   col_q [K];
    logic [PIX_W-1:0]   col_d [K];
    logic [WIN_W-1:0]   win_q, win_d;
    logic [AW-1:0]      res_addr_q, res_addr_d;
    logic [SUM_W-1:0]   res_data_q, res_data_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            oy_q        <= '0;
            ox_q        <= '0;
            fetch_row_q <= '0;
            fetch_cnt_q <= '0;
            img_addr_q  <= '0;
            rd_vld_q    <= 1'b0;
            rd_row_q    <= '0;
            col_q       <= '{default: '0};
            win_q       <= '0;
            res_addr_q  <= '0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            oy_q        <= oy_d;
            ox_q        <= ox_d;
            fetch_row_q <= fetch_row_d;
            fetch_cnt_q <= fetch_cnt_d;
            img_addr_q  <= img_addr_d;
            rd_vld_q    <= rd_vld_d;
            rd_row_q    <= rd_row_d;
            col_q       <= col_d;
            win_q       <= win_d;
            res_addr_q  <= res_addr_d;
            res_data_q  <= res_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        oy_d        = oy_q;
        ox_d        = ox_q;
        fetch_row_d = fetch_row_q;
        fetch_cnt_d = fetch_cnt_q;
        img_addr_d  = img_addr_q;
        rd_vld_d    = 1'b0;
        rd_row_d    = fetch_row_q;
        res_addr_d  = res_addr_q;
        res_data_d  = res_data_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d     = S_FETCH;
                    oy_d        = '0;
                    ox_d        = '0;
                    fetch_row_d = '0;
                    fetch_cnt_d = FW'(K * K);
                    img_addr_d  = '0;
                end
            end
            S_FETCH: begin
                rd_vld_d    = 1'b1;
                fetch_cnt_d = fetch_cnt_q - FW'(1);
                if (fetch_cnt_q == FW'(1)) begin
                    state_d = S_DRAIN;
                end else if (fetch_row_q == RW'(K - 1)) begin
                    // bottom of a column: jump back to the top row, one column right
                    fetch_row_d = '0;
                    img_addr_d  = img_addr_q - AW'((K - 1) * IMG_W) + AW'(1);
                end else begin
                    fetch_row_d = fetch_row_q + RW'(1);
                    img_addr_d  = img_addr_q + AW'(IMG_W);
                end
            end
            S_DRAIN: state_d = S_FIRE;
            S_FIRE:  state_d = S_WAIT;
            S_WAIT: begin
                if (bus.flt_end) begin
                    state_d    = S_WRITE;
                    res_data_d = bus.flt_out;
                    res_addr_d = AW'(oy_q) * AW'(OUT_W) + AW'(ox_q);
                end
            end
            S_WRITE: begin
                fetch_row_d = '0;
                if (ox_q != CW'(OUT_W - 1)) begin
                    state_d     = S_FETCH;
                    ox_d        = ox_q + CW'(1);
                    fetch_cnt_d = FW'(K);
                    img_addr_d  = AW'(oy_q) * AW'(IMG_W) + AW'(ox_q) + AW'(K);
                end else if (oy_q != CW'(OUT_W - 1)) begin
                    state_d     = S_FETCH;
                    ox_d        = '0;
                    oy_d        = oy_q + CW'(1);
                    fetch_cnt_d = FW'(K * K);
                    img_addr_d  = (AW'(oy_q) + AW'(1)) * AW'(IMG_W);
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Pixels collect per column; the fifth one pushes the whole column into win.
    always_comb begin
        col_d = col_q;
        win_d = win_q;
        if (rd_vld_q) begin
            col_d[rd_row_q] = bus.img_data;
            if (rd_row_q == RW'(K - 1)) begin
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K - 1; c++) begin
                        win_d[WIN_W-1-PIX_W*(r*K+c) -: PIX_W] =
                            win_q[WIN_W-1-PIX_W*(r*K+c+1) -: PIX_W];
                    end
                    win_d[WIN_W-1-PIX_W*(r*K+K-1) -: PIX_W] = col_d[r];
                end
            end
        end
    end

    assign bus.busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.img_rd    = (state_q == S_FETCH);
    assign bus.img_addr  = img_addr_q;
    assign bus.win       = win_q;
    assign bus.flt_start = (state_q == S_FIRE);
    assign bus.res_we    = (state_q == S_WRITE);
    assign bus.res_addr  = res_addr_q;
    assign bus.res_data  = res_data_q;

endmodule

// File: tb/tb_conv_28_24_ctrl.sv
// Directed bench for conv_28_24_ctrl: image RAM and filter models, per-scenario tasks.
module tb_conv_28_24_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    conv_28_24_ctrl_if bus ();

    conv_28_24_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int pattern = 0;
    int lat     = 3;
    bit spur_en = 1'b0;

    typedef struct packed {
        int   wr;
        int   aerr;
        int   derr;
        int   done;
        int   fs;
        int   rd;
        int   rdbad;
        int   rdwait;
        logic ok;
        logic busy_done;
    } run_t;

    function automatic logic [8:0] pix(input logic [9:0] a);
        int r, c;
        r = int'(a) / 28;
        c = int'(a) % 28;
        case (pattern)
            0:       return 9'd1;
            1:       return 9'(c);
            2:       return (r == 0 && c == 0) ? 9'd7 : 9'd0;
            default: return 9'h100;
        endcase
    endfunction

    function automatic logic [14:0] exp_sum(input int a);
        int ox;
        ox = a % 24;
        case (pattern)
            0:       return 15'd25;
            1:       return 15'(25 * ox + 50);
            2:       return (a == 0) ? 15'd7 : 15'd0;
            default: return 15'h6700;
        endcase
    endfunction

    // image RAM: one-cycle read latency
    always @(posedge clk) begin
        if (bus.img_rd) bus.img_data <= pix(bus.img_addr);
    end

    // filter model: all +1 weights, configurable latency, optional stray flt_end during reads
    int          f_cnt = 0;
    bit          f_busy = 1'b0;
    logic [14:0] f_acc = '0;
    always @(posedge clk) begin : filter_model
        logic [14:0] acc;
        logic [8:0]  px;
        bus.flt_end <= 1'b0;
        bus.flt_out <= 15'h5A5A;
        if (reset) begin
            f_busy <= 1'b0;
        end else if (bus.flt_start) begin
            acc = '0;
            for (int i = 0; i < 25; i++) begin
                px  = bus.win[224-9*i -: 9];
                acc = acc + {{6{px[8]}}, px};
            end
            f_acc <= acc;
            if (lat <= 1) begin
                bus.flt_end <= 1'b1;
                bus.flt_out <= acc;
            end else begin
                f_busy <= 1'b1;
                f_cnt  <= lat - 1;
            end
        end else if (f_busy) begin
            if (f_cnt == 1) begin
                bus.flt_end <= 1'b1;
                bus.flt_out <= f_acc;
                f_busy      <= 1'b0;
            end
            f_cnt <= f_cnt - 1;
        end else if (spur_en && bus.img_rd) begin
            bus.flt_end <= 1'b1;
            bus.flt_out <= 15'h1234;
        end
    end

    // monitor: tallies only; comparisons live in the test tasks
    int m_wr = 0, m_aerr = 0, m_derr = 0, m_done = 0, m_fs = 0;
    int m_rd = 0, m_rdbad = 0, m_rdwait = 0, exp_addr = 0;
    logic [9:0]  rd_log  [4096];
    logic [14:0] res_log [1024];
    always @(negedge clk) begin
        if (reset) begin
            exp_addr = 0;
        end else begin
            if (bus.res_we) begin
                if (int'(bus.res_addr) != exp_addr) m_aerr++;
                if (bus.res_data !== exp_sum(int'(bus.res_addr))) m_derr++;
                res_log[bus.res_addr] = bus.res_data;
                m_wr++;
                exp_addr = (exp_addr == 575) ? 0 : exp_addr + 1;
            end
            if (bus.done) m_done++;
            if (bus.flt_start) m_fs++;
            if (bus.img_rd) begin
                rd_log[m_rd % 4096] = bus.img_addr;
                m_rd++;
                if (bus.img_addr >= 10'd784) m_rdbad++;
                if (f_busy) m_rdwait++;
            end
        end
    end

    int b_wr, b_aerr, b_derr, b_done, b_fs, b_rd, b_rdbad, b_rdwait;

    task automatic snap();
        b_wr = m_wr; b_aerr = m_aerr; b_derr = m_derr; b_done = m_done;
        b_fs = m_fs; b_rd = m_rd; b_rdbad = m_rdbad; b_rdwait = m_rdwait;
    endtask

    task automatic kick();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output logic ok, output logic busy_at_done);
        ok = 1'b0;
        busy_at_done = 1'b1;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            if (bus.done === 1'b1) begin
                ok = 1'b1;
                busy_at_done = bus.busy;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic collect(inout run_t r);
        @(negedge clk);
        @(negedge clk);
        r.wr = m_wr - b_wr; r.aerr = m_aerr - b_aerr; r.derr = m_derr - b_derr;
        r.done = m_done - b_done; r.fs = m_fs - b_fs; r.rd = m_rd - b_rd;
        r.rdbad = m_rdbad - b_rdbad; r.rdwait = m_rdwait - b_rdwait;
    endtask

    task automatic run_full(input int max_cyc, output run_t r);
        logic ok, bd;
        r = '0;
        snap();
        kick();
        wait_done(max_cyc, ok, bd);
        r.ok = ok;
        r.busy_done = bd;
        collect(r);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus.busy, bus.done, bus.img_rd, bus.flt_start, bus.res_we} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_strobes: got %b want 00000",
                     {bus.busy, bus.done, bus.img_rd, bus.flt_start, bus.res_we});
        end
        n_cmp++;
        if (bus.img_addr !== 10'd0) begin
            n_bad++; $display("FAIL reset_img_addr: got %0d want 0", bus.img_addr);
        end
        n_cmp++;
        if (bus.win !== 225'd0) begin
            n_bad++; $display("FAIL reset_win: got %h want 0", bus.win);
        end
        n_cmp++;
        if (bus.res_addr !== 10'd0 || bus.res_data !== 15'd0) begin
            n_bad++;
            $display("FAIL reset_res: got addr %0d data %0d want 0 0", bus.res_addr, bus.res_data);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_all_ones();
        run_t r;
        pattern = 0; lat = 3; spur_en = 1'b0;
        run_full(20000, r);
        n_cmp++;
        if (r.ok !== 1'b1) begin n_bad++; $display("FAIL ones_done_seen: got %0d want 1", r.ok); end
        n_cmp++;
        if (r.busy_done !== 1'b0) begin n_bad++; $display("FAIL ones_busy_at_done: got %0d want 0", r.busy_done); end
        n_cmp++;
        if (r.wr != 576) begin n_bad++; $display("FAIL ones_writes: got %0d want 576", r.wr); end
        n_cmp++;
        if (r.aerr != 0) begin n_bad++; $display("FAIL ones_addr_order: got %0d bad want 0", r.aerr); end
        n_cmp++;
        if (r.derr != 0) begin n_bad++; $display("FAIL ones_data: got %0d bad want 0", r.derr); end
        n_cmp++;
        if (r.done != 1) begin n_bad++; $display("FAIL ones_done_pulses: got %0d want 1", r.done); end
        n_cmp++;
        if (r.rd != 3360 || r.rdbad != 0) begin
            n_bad++; $display("FAIL ones_reads: got %0d (%0d out of range) want 3360 (0)", r.rd, r.rdbad);
        end
        n_cmp++;
        if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL ones_busy_after: got %0d want 0", bus.busy); end
    endtask

    task automatic test_column_ramp();
        run_t r;
        pattern = 1; lat = 3; spur_en = 1'b0;
        run_full(20000, r);
        n_cmp++;
        if (r.wr != 576 || r.derr != 0 || r.aerr != 0) begin
            n_bad++;
            $display("FAIL ramp_run: got wr %0d derr %0d aerr %0d want 576 0 0", r.wr, r.derr, r.aerr);
        end
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (rd_log[(b_rd + 25 + k) % 4096] !== 10'(5 + 28 * k)) begin
                n_bad++;
                $display("FAIL ramp_step_addr%0d: got %0d want %0d", k,
                         rd_log[(b_rd + 25 + k) % 4096], 5 + 28 * k);
            end
        end
        n_cmp++;
        if (res_log[23] !== 15'd625) begin n_bad++; $display("FAIL ramp_ox23: got %0d want 625", res_log[23]); end
        n_cmp++;
        if (res_log[247] !== 15'd225) begin n_bad++; $display("FAIL ramp_oy10_ox7: got %0d want 225", res_log[247]); end
    endtask

    task automatic test_single_pixel();
        run_t r;
        logic ok, bd;
        logic [224:0] exp_w;
        bit seen;
        pattern = 2; lat = 3; spur_en = 1'b0;
        r = '0;
        exp_w = '0;
        exp_w[224:216] = 9'd7;
        snap();
        kick();
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (bus.flt_start === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen || bus.win !== exp_w) begin
            n_bad++; $display("FAIL pix_first_win: got %h want %h", bus.win, exp_w);
        end
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (bus.flt_start === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen || bus.win !== 225'd0) begin
            n_bad++; $display("FAIL pix_second_win: got %h want 0", bus.win);
        end
        wait_done(20000, ok, bd);
        r.ok = ok;
        collect(r);
        n_cmp++;
        if (r.ok !== 1'b1 || r.wr != 576 || r.derr != 0) begin
            n_bad++; $display("FAIL pix_run: got ok %0d wr %0d derr %0d want 1 576 0", r.ok, r.wr, r.derr);
        end
        n_cmp++;
        if (res_log[0] !== 15'd7 || res_log[1] !== 15'd0) begin
            n_bad++; $display("FAIL pix_results: got %0d,%0d want 7,0", res_log[0], res_log[1]);
        end
    endtask

    task automatic test_negative();
        run_t r;
        pattern = 3; lat = 3; spur_en = 1'b0;
        run_full(20000, r);
        n_cmp++;
        if (r.ok !== 1'b1 || r.wr != 576 || r.derr != 0) begin
            n_bad++; $display("FAIL neg_run: got ok %0d wr %0d derr %0d want 1 576 0", r.ok, r.wr, r.derr);
        end
        n_cmp++;
        if (res_log[0] !== 15'h6700 || res_log[575] !== 15'h6700) begin
            n_bad++; $display("FAIL neg_value: got %h,%h want 6700", res_log[0], res_log[575]);
        end
    endtask

    task automatic test_slow_filter();
        run_t r;
        pattern = 1; lat = 10; spur_en = 1'b1;
        run_full(30000, r);
        spur_en = 1'b0;
        n_cmp++;
        if (r.ok !== 1'b1 || r.wr != 576) begin
            n_bad++; $display("FAIL slow_writes: got ok %0d wr %0d want 1 576", r.ok, r.wr);
        end
        n_cmp++;
        if (r.aerr != 0 || r.derr != 0) begin
            n_bad++; $display("FAIL slow_results: got aerr %0d derr %0d want 0 0", r.aerr, r.derr);
        end
        n_cmp++;
        if (r.fs != 576) begin n_bad++; $display("FAIL slow_flt_starts: got %0d want 576", r.fs); end
        n_cmp++;
        if (r.rdwait != 0) begin n_bad++; $display("FAIL slow_rd_in_wait: got %0d want 0", r.rdwait); end
        lat = 3;
    endtask

    task automatic test_reset_restart();
        run_t r;
        logic ok, bd;
        bit hit;
        int w0, rd0;
        pattern = 0; lat = 3; spur_en = 1'b0;
        snap();
        kick();
        hit = 1'b0;
        for (int i = 0; i < 5000 && !hit; i++) begin
            @(negedge clk);
            if (m_wr - b_wr >= 100) hit = 1'b1;
        end
        n_cmp++;
        if (!hit) begin n_bad++; $display("FAIL rst_reach100: got %0d writes want 100", m_wr - b_wr); end
        reset = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.busy, bus.done, bus.img_rd, bus.flt_start, bus.res_we} !== 5'b0) begin
            n_bad++;
            $display("FAIL rst_mid_strobes: got %b want 00000",
                     {bus.busy, bus.done, bus.img_rd, bus.flt_start, bus.res_we});
        end
        n_cmp++;
        if (bus.img_addr !== 10'd0 || bus.res_addr !== 10'd0 || bus.res_data !== 15'd0) begin
            n_bad++;
            $display("FAIL rst_mid_regs: got %0d %0d %0d want 0 0 0", bus.img_addr, bus.res_addr, bus.res_data);
        end
        n_cmp++;
        if (bus.win !== 225'd0) begin n_bad++; $display("FAIL rst_mid_win: got %h want 0", bus.win); end
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        w0 = m_wr;
        rd0 = m_rd;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0 || m_wr != w0 || m_rd != rd0) begin
            n_bad++;
            $display("FAIL rst_start_ignored: got busy %0d wr %0d rd %0d want 0 0 0",
                     bus.busy, m_wr - w0, m_rd - rd0);
        end
        r = '0;
        snap();
        kick();
        repeat (20) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(20000, ok, bd);
        r.ok = ok;
        collect(r);
        n_cmp++;
        if (rd_log[b_rd % 4096] !== 10'd0) begin
            n_bad++; $display("FAIL restart_img_addr: got %0d want 0", rd_log[b_rd % 4096]);
        end
        n_cmp++;
        if (r.ok !== 1'b1 || r.wr != 576 || r.aerr != 0 || r.done != 1) begin
            n_bad++;
            $display("FAIL restart_run: got ok %0d wr %0d aerr %0d done %0d want 1 576 0 1",
                     r.ok, r.wr, r.aerr, r.done);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        test_reset();
        test_all_ones();
        test_column_ramp();
        test_single_pixel();
        test_negative();
        test_slow_filter();
        test_reset_restart();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got no finish want finish before 900000 ns");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/conv_28_24_ctrl.md
Name: conv_28_24_ctrl

Overview:
- Scheduler that sweeps a 5x5 window across a 28x28 image of 9-bit signed pixels, one window per output.
- Reads pixels from an external image RAM and packs each 5x5 window into the 225-bit bus of the binary-weight filter datapath.
- Fires that datapath, waits for its end_flag, then writes each 15-bit sum to a 24x24 result RAM in raster order.
- Sits between the image buffer and the filter; the layer sequencer drives start and waits for done.

Parameters:
IMG_W  28  image width/height in pixels
K  5  window size (fixed; window bus is K*K*PIX_W = 225 bits)
PIX_W  9  pixel width, two's complement
SUM_W  15  filter result width, two's complement
OUT_W  24  derived localparam IMG_W-K+1; not overridable
AW  10  image and result address width

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
start  in  1  one-cycle request to process the full image
busy  out  1  high from the cycle after accepted start until done
done  out  1  one-cycle pulse after the final result write
img_rd  out  1  image read strobe
img_addr  out  AW  pixel address, row*28+col
img_data  in  PIX_W  read data, valid the cycle after img_rd
win  out  225  window; element (r,c), idx=r*5+c, at bits [224-9*idx -: 9] (top-left in MSBs)
flt_start  out  1  one-cycle pulse to filter datapath
flt_out  in  SUM_W  filter sum, valid when flt_end=1
flt_end  in  1  filter completion pulse
res_we  out  1  result write strobe
res_addr  out  AW  oy*24+ox
res_data  out  SUM_W  result value

Behaviour:
- Reset: every output is 0 (busy, done, img_rd, img_addr, win, flt_start, res_we, res_addr, res_data); FSM goes to IDLE; counters oy=ox=0.
- Reset overrides start in the same cycle. Reset mid-run aborts immediately; no further reads or writes occur.
- IDLE: start=1 -> FETCH with oy=ox=0 and fetch count 25 (full refill); busy=1 from the next cycle.
- start while busy is ignored.
- FETCH: one read per cycle, img_rd=1.
  - Order: column by column, rows oy..oy+4 top to bottom within each column.
  - Refill (ox=0) reads columns 0..4. Step (ox>0) reads column ox+4 only, 5 reads.
- Capture: each returning img_data goes into a 5-entry column register at row index.
  - When the 5th pixel of a column lands, win shifts left one column (column 0 drops out) and the new column enters column 4.
- DRAIN: one cycle after the last read, to capture the final pixel. img_rd=0.
- FIRE: flt_start=1 for exactly one cycle. win holds stable from FIRE until leaving WAIT.
- WAIT: hold until flt_end=1. The filter latency is not assumed; nominal is 3 cycles after flt_start, and any latency of 1 or more must work.
  - On flt_end, register flt_out into res_data and res_addr=oy*24+ox.
  - flt_end outside WAIT is ignored.
- WRITE: res_we=1 for one cycle, then advance.
  - ox<23: ox+1, step fetch (5 reads).
  - ox=23, oy<23: ox=0, oy+1, refill (25 reads).
  - ox=23, oy=23: DONE.
- DONE: done=1 for one cycle, busy=0 in the same cycle, then IDLE.
- res_data and res_addr hold their last values between writes. win holds after completion.
- Steady-state step: 5 FETCH + 1 DRAIN + 1 FIRE + L WAIT + 1 WRITE cycles, where L is the filter latency.
- Exactly 576 writes per run, addresses strictly 0..575 ascending. No arithmetic on data; sums pass through unchanged.

Test Plan:
1. All pixels=1, filter model all +1 weights, latency 3 -> 576 writes, res_data=25 each, res_addr 0..575 in order, one done pulse, busy low after.
2. Pixel(r,c)=c, all +1 weights -> res_data=25*ox+50 for every oy; ox=23 gives 625. img_addr sequence for output (0,1) is 5,33,61,89,117.
3. Only pixel(0,0)=7, others 0 -> at the first flt_start win[224:216]=7 and the rest 0. From the second window on, win=0.
4. All pixels=-256 (0x100), all +1 weights -> every res_data=-6400 (15'h6700); no overflow.
5. Filter model with latency 10 -> controller stays in WAIT, img_rd=0, one flt_start per window; 576 correct writes.
6. Reset at result 100 -> next cycle all outputs 0. start asserted with reset is ignored. start during busy is ignored. A fresh start restarts at res_addr 0 and img_addr 0.
